// File: rtl/ahb_slave_mem_pkg.sv
// ahb_pkg: shared AHB-Lite types, response codes and byte-lane helper
package ahb_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, NONSEQ, SEQ} htrans_e;
    typedef enum logic [2:0] {
        SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_DWORD,
        SIZE_4WORD, SIZE_8WORD, SIZE_16WORD, SIZE_32WORD
    } hsize_e;
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;
    // lane mask for a transfer of 2^hsize bytes at the given offset inside a dw-bit word
    function automatic logic [7:0] byte_strobe(input logic [2:0] hsize, input logic [2:0] addr_lsbs, input int dw);
        logic [2:0] lsb;
        logic [15:0] mask;
        lsb = addr_lsbs & 3'(dw / 8 - 1);
        mask = (16'd1 << (16'd1 << hsize)) - 16'd1;
        return 8'(mask << lsb);
    endfunction
endpackage

// File: rtl/ahb_slave_mem_if.sv
// ahb_slave_mem_if: AHB-Lite bus bundle between a master/interconnect and the slave memory
interface ahb_slave_mem_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          hsel;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic [DW-1:0] hwdata;
    logic          hready;
    logic          hreadyout;
    logic          hresp;
    logic [DW-1:0] hrdata;
    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );
    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_slave_mem_sram.sv
// ahb_sram_array: word array with per-byte write enables and an asynchronous read port
module ahb_sram_array #(
    parameter int DEPTH = 1024,
    parameter int DW = 32,
    localparam int IW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] idx,
    input  logic [DW/8-1:0] strb,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        for (int b = 0; b < DW / 8; b++)
            if (we && strb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    assign rdata = mem[idx];
endmodule

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite slave memory with wait states, byte-lane writes and two-cycle ERROR
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32,
    parameter int MEM_DEPTH = 1024,
    parameter logic [AHB_ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int WAIT_STATES = 0
) (
    input logic clk,
    input logic rst_n,
    ahb_slave_mem_if.slave bus
);
    localparam int AW = AHB_ADDR_WIDTH;
    localparam int DW = AHB_DATA_WIDTH;
    localparam int NB = DW / 8;
    localparam int LB = $clog2(NB);
    localparam int IW = $clog2(MEM_DEPTH);
    localparam logic [AW:0] SPAN = (AW + 1)'(MEM_DEPTH * NB);
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_e;
    state_e st, st_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [IW-1:0] idx_q;
    logic [2:0] lsb_q, size_q;
    logic write_q;
    logic [DW-1:0] rdata, hrdata_q;
    logic [NB-1:0] strb;
    logic [AW-1:0] off;
    logic stall, done, err, bad, accept;
    // an address below BASE_ADDR wraps to a huge offset, so one compare covers both range ends
    assign off = bus.haddr - BASE_ADDR;
    assign bad = {1'b0, off} >= SPAN || bus.hsize > 3'(LB) ||
                 |(bus.haddr[2:0] & ((3'd1 << bus.hsize) - 3'd1));
    assign stall = st == ST_ERR1 || (st == ST_WAIT && cnt != '0);
    assign done = st == ST_WAIT && cnt == '0;
    assign err = st == ST_ERR1 || st == ST_ERR2;
    assign accept = bus.hsel && bus.hready && bus.htrans[1] && !stall;
    always_comb begin
        st_nxt = stall ? (st == ST_ERR1 ? ST_ERR2 : ST_WAIT) : accept ? (bad ? ST_ERR1 : ST_WAIT) : ST_IDLE;
        cnt_nxt = stall && st == ST_WAIT ? cnt - 4'd1 : accept && !bad ? 4'(WAIT_STATES) : '0;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            st <= ST_IDLE;
            cnt <= '0;
            idx_q <= '0;
            lsb_q <= '0;
            size_q <= '0;
            write_q <= 1'b0;
            hrdata_q <= '0;
        end else begin
            st <= st_nxt;
            cnt <= cnt_nxt;
            hrdata_q <= bus.hrdata;
            if (accept) begin
                idx_q <= off[LB +: IW];
                lsb_q <= bus.haddr[2:0];
                size_q <= bus.hsize;
                write_q <= bus.hwrite;
            end
        end
    assign strb = NB'(byte_strobe(size_q, lsb_q, DW));
    ahb_sram_array #(.DEPTH(MEM_DEPTH), .DW(DW)) u_sram (
        .clk(clk),
        .we(done && write_q),
        .idx(idx_q),
        .strb(strb),
        .wdata(bus.hwdata),
        .rdata(rdata)
    );
    assign bus.hreadyout = !stall;
    assign bus.hresp = err ? HRESP_ERROR : HRESP_OKAY;
    assign bus.hrdata = err ? '0 : done && !write_q ? rdata : hrdata_q;
endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb_ahb_slave_mem: table-driven pipelined AHB master with an expected-response scoreboard
module tb_ahb_slave_mem;
    import ahb_pkg::*;
    typedef struct {
        logic hs; htrans_e tr; logic wr; logic [2:0] sz; logic [31:0] addr;
        logic [31:0] wd; logic [31:0] erd; logic eresp; int estall;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n, sel, hsel, hwrite, hready_ext;
    htrans_e htrans;
    logic [2:0] hsize, hburst;
    logic [31:0] haddr, hwdata;
    logic rdy, resp;
    logic [31:0] rdata;
    int n_vec = 0, n_bad = 0;
    vec_t sb [$];
    vec_t ta [$], tb3 [$], tbur [$], tone [$];
    int cyc;
    always #5 clk = ~clk;
    ahb_slave_mem_if #(.AW(32), .DW(32)) i0 ();
    ahb_slave_mem_if #(.AW(32), .DW(32)) i3 ();
    assign i0.hsel = hsel && !sel;
    assign i3.hsel = hsel && sel;
    assign i0.haddr = haddr;    assign i3.haddr = haddr;
    assign i0.htrans = htrans;  assign i3.htrans = htrans;
    assign i0.hwrite = hwrite;  assign i3.hwrite = hwrite;
    assign i0.hsize = hsize;    assign i3.hsize = hsize;
    assign i0.hburst = hburst;  assign i3.hburst = hburst;
    assign i0.hwdata = hwdata;  assign i3.hwdata = hwdata;
    assign i0.hready = i0.hreadyout && hready_ext;
    assign i3.hready = i3.hreadyout && hready_ext;
    assign rdy = sel ? i3.hreadyout : i0.hreadyout;
    assign resp = sel ? i3.hresp : i0.hresp;
    assign rdata = sel ? i3.hrdata : i0.hrdata;
    ahb_slave_mem #(.WAIT_STATES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(i0));
    ahb_slave_mem #(.WAIT_STATES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(i3));

    function automatic vec_t v(input logic hs, input htrans_e tr, input logic wr, input logic [2:0] sz,
                               input logic [31:0] addr, wd, erd, input logic eresp, input int estall);
        v = '{hs, tr, wr, sz, addr, wd, erd, eresp, estall};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // drives one address phase per accepted cycle while the previous beat's data phase runs
    task automatic run(input vec_t ops [$], output int cycles);
        vec_t dph, e;
        bit dv = 0, started = 0;
        int k = 0, st = 0, guard = 0;
        cycles = 0;
        while ((k < ops.size() || dv) && guard < 500) begin
            guard++;
            if (k < ops.size()) begin
                hsel = ops[k].hs; htrans = ops[k].tr; hwrite = ops[k].wr;
                hsize = ops[k].sz; haddr = ops[k].addr; hburst = 3'b001;
            end else begin
                hsel = 1'b0; htrans = IDLE;
            end
            hwdata = dv && dph.wr ? dph.wd : 32'h0;
            @(negedge clk);
            started |= dv;
            if (started) cycles++;
            if (dv && !rdy) begin
                st++;
                chk("stall_resp", 32'(resp), 32'(dph.eresp));
            end else if (dv) begin
                e = sb.pop_front();
                chk("stalls", 32'(st), 32'(e.estall));
                chk("resp", 32'(resp), 32'(e.eresp));
                if (!e.wr || e.eresp) chk("rdata", rdata, e.erd);
                dv = 0;
            end else begin
                chk("idle_ready", 32'(rdy), 32'd1);
                chk("idle_resp", 32'(resp), 32'd0);
            end
            if (rdy && k < ops.size()) begin
                if (ops[k].hs && ops[k].tr inside {NONSEQ, SEQ}) begin
                    dph = ops[k]; sb.push_back(ops[k]); dv = 1; st = 0;
                end
                k++;
            end
            @(posedge clk); #1;
        end
        chk("drained", 32'(dv || k < ops.size()), 32'd0);
    endtask

    initial begin
        ta = '{
            v(1, NONSEQ, 1, 2, 32'h10,   32'hDEADBEEF, 32'h0,        0, 0),
            v(1, NONSEQ, 0, 2, 32'h10,   32'h0,        32'hDEADBEEF, 0, 0),
            v(1, NONSEQ, 1, 2, 32'h10,   32'h11223344, 32'h0,        0, 0),
            v(1, NONSEQ, 1, 0, 32'h13,   32'hAAAAAAAA, 32'h0,        0, 0),
            v(1, NONSEQ, 1, 1, 32'h10,   32'h55665566, 32'h0,        0, 0),
            v(1, NONSEQ, 0, 2, 32'h10,   32'h0,        32'hAA225566, 0, 0),
            v(1, NONSEQ, 1, 2, 32'h0,    32'h5A5A5A5A, 32'h0,        0, 0),
            v(1, NONSEQ, 1, 2, 32'h1000, 32'h12345678, 32'h0,        1, 1),
            v(1, NONSEQ, 0, 2, 32'h0,    32'h0,        32'h5A5A5A5A, 0, 0),
            v(1, NONSEQ, 0, 2, 32'h02,   32'h0,        32'h0,        1, 1),
            v(1, NONSEQ, 0, 2, 32'h10,   32'h0,        32'hAA225566, 0, 0),
            v(1, NONSEQ, 1, 2, 32'hFFC,  32'hCAFEF00D, 32'h0,        0, 0),
            v(1, NONSEQ, 0, 2, 32'hFFC,  32'h0,        32'hCAFEF00D, 0, 0),
            v(1, NONSEQ, 0, 3, 32'h10,   32'h0,        32'h0,        1, 1),
            v(1, NONSEQ, 1, 2, 32'h20,   32'h20202020, 32'h0,        0, 0),
            v(1, NONSEQ, 1, 1, 32'h21,   32'hFFFFFFFF, 32'h0,        1, 1),
            v(1, NONSEQ, 0, 2, 32'h20,   32'h0,        32'h20202020, 0, 0),
            v(1, NONSEQ, 0, 0, 32'h11,   32'h0,        32'hAA225566, 0, 0),
            v(1, NONSEQ, 1, 2, 32'h40,   32'h0A0A0A0A, 32'h0,        0, 0),
            v(1, NONSEQ, 0, 2, 32'h40,   32'h0,        32'h0A0A0A0A, 0, 0),
            v(1, IDLE,   0, 2, 32'h0,    32'h0,        32'h0,        0, 0),
            v(1, BUSY,   0, 2, 32'h0,    32'h0,        32'h0,        0, 0),
            v(1, NONSEQ, 1, 2, 32'h44,   32'h0B0B0B0B, 32'h0,        0, 0),
            v(1, SEQ,    0, 2, 32'h44,   32'h0,        32'h0B0B0B0B, 0, 0),
            v(0, NONSEQ, 1, 2, 32'h40,   32'hFFFFFFFF, 32'h0,        0, 0),
            v(1, NONSEQ, 0, 2, 32'h40,   32'h0,        32'h0A0A0A0A, 0, 0),
            v(1, NONSEQ, 1, 2, 32'h80,   32'h12121212, 32'h0,        0, 0)
        };
        tb3 = '{
            v(1, NONSEQ, 1, 2, 32'h0,    32'hB0B00000, 32'h0, 0, 3),
            v(1, NONSEQ, 1, 2, 32'h4,    32'hB0B00001, 32'h0, 0, 3),
            v(1, NONSEQ, 1, 2, 32'h8,    32'hB0B00002, 32'h0, 0, 3),
            v(1, NONSEQ, 1, 2, 32'hC,    32'hB0B00003, 32'h0, 0, 3),
            v(1, NONSEQ, 0, 2, 32'h1000, 32'h0,        32'h0, 1, 1)
        };
        tbur = '{
            v(1, NONSEQ, 0, 2, 32'h0, 32'h0, 32'hB0B00000, 0, 3),
            v(1, SEQ,    0, 2, 32'h4, 32'h0, 32'hB0B00001, 0, 3),
            v(1, SEQ,    0, 2, 32'h8, 32'h0, 32'hB0B00002, 0, 3),
            v(1, SEQ,    0, 2, 32'hC, 32'h0, 32'hB0B00003, 0, 3)
        };
        sel = 0; rst_n = 0; hsel = 0; htrans = IDLE; hwrite = 0; hsize = 3'd2;
        hburst = 3'b001; haddr = '0; hwdata = '0; hready_ext = 1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", 32'(i0.hreadyout), 32'd1);
        chk("rst_resp0", 32'(i0.hresp), 32'd0);
        chk("rst_rdata0", i0.hrdata, 32'h0);
        chk("rst_ready3", 32'(i3.hreadyout), 32'd1);
        chk("rst_resp3", 32'(i3.hresp), 32'd0);
        chk("rst_rdata3", i3.hrdata, 32'h0);
        rst_n = 1;
        @(posedge clk); #1;
        run(ta, cyc);
        sel = 1;
        run(tb3, cyc);
        run(tbur, cyc);
        chk("burst_cycles", 32'(cyc), 32'd16);
        // reset lands while a write waits out its wait states; the write must be dropped
        hsel = 1; htrans = NONSEQ; hwrite = 1; hsize = 3'd2; haddr = 32'h0;
        @(posedge clk); #1;
        hsel = 0; htrans = IDLE; hwdata = 32'h99999999;
        @(negedge clk);
        chk("mid_wait_stall", 32'(rdy), 32'd0);
        rst_n = 0; #1;
        chk("mid_rst_ready", 32'(i3.hreadyout), 32'd1);
        chk("mid_rst_resp", 32'(i3.hresp), 32'd0);
        chk("mid_rst_rdata", i3.hrdata, 32'h0);
        @(negedge clk);
        chk("mid_rst_hold", 32'(i3.hreadyout), 32'd1);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        tone = '{v(1, NONSEQ, 0, 2, 32'h0, 32'h0, 32'hB0B00000, 0, 3)};
        run(tone, cyc);
        // another slave holds hready low: the NONSEQ write must not be taken
        sel = 0;
        hready_ext = 0; hsel = 1; htrans = NONSEQ; hwrite = 1; hsize = 3'd2; haddr = 32'h80;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ext_stall_ready", 32'(i0.hreadyout), 32'd1);
            @(posedge clk); #1;
            hwdata = 32'h77777777;
        end
        hsel = 0; htrans = IDLE; hready_ext = 1;
        @(posedge clk); #1;
        tone = '{v(1, NONSEQ, 0, 2, 32'h80, 32'h0, 32'h12121212, 0, 0)};
        run(tone, cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
